// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic path: op encoding used by decode, the unit and benches.
package logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_XNOR  = 3'd3,
        OP_NAND  = 3'd4,
        OP_NOR   = 3'd5,
        OP_ANDN  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

endpackage

// File: rtl/logic_op_comb.sv
// Combinational WIDTH-bit bitwise operator; every result bit depends only on a[i], b[i].
module logic_op_comb
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_ANDN:  y = a & ~b;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: one output register backed by a one-entry result skid,
// valid/ready on both sides, result flags and a saturating accepted-op counter.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count,
    input  logic             cnt_clr
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] res_p0;
    logic [WIDTH-1:0] src_p0;
    logic             accept_p0;
    logic             load_p0;

    logic [WIDTH-1:0] out_data_p1;
    logic             out_zero_p1;
    logic             out_par_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] skid_data_p1;
    logic             skid_vld_p1;
    logic [CNT_W-1:0] cnt_p1;

    logic_op_comb #(.WIDTH(WIDTH)) u_op (
        .a  (in_a),
        .b  (in_b),
        .op (in_op),
        .y  (res_p0)
    );

    assign accept_p0 = in_valid && in_ready;
    assign load_p0   = !vld_p1 || out_ready;
    // A full skid always holds the older result, so it wins the output mux.
    assign src_p0    = skid_vld_p1 ? skid_data_p1 : res_p0;

    // ---- stage p0 -> p1: output register, skid and counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
            out_zero_p1 <= 1'b1;
            out_par_p1  <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else begin
            if (load_p0) begin
                vld_p1 <= skid_vld_p1 || accept_p0;
                if (skid_vld_p1 || accept_p0) begin
                    out_data_p1 <= src_p0;
                    out_zero_p1 <= ~|src_p0;
                    out_par_p1  <= ^src_p0;
                end
                skid_vld_p1 <= 1'b0;
            end else if (accept_p0) begin
                skid_vld_p1 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!load_p0 && accept_p0) begin
            skid_data_p1 <= res_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
        end else if (cnt_clr) begin
            cnt_p1 <= '0;
        end else if (accept_p0) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign in_ready   = !skid_vld_p1;
    assign out_valid  = vld_p1;
    assign out_data   = out_data_p1;
    assign out_zero   = out_zero_p1;
    assign out_parity = out_par_p1;
    assign op_count   = cnt_p1;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed vector table, backpressure/reset sequences,
// randomized traffic against a truth-table reference model, and a 1-bit exhaustive sweep.
module tb_logic_unit_pipe;
    import logic_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_parity, cnt_clr;
    logic [31:0] in_a, in_b, out_data;
    logic [2:0]  in_op;
    logic [15:0] op_count;

    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_zero, n_out_parity, n_cnt_clr;
    logic [0:0]  n_in_a, n_in_b, n_out_data;
    logic [2:0]  n_in_op;
    logic [3:0]  n_op_count;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    bit mon_en = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_parity(out_parity), .op_count(op_count), .cnt_clr(cnt_clr)
    );

    logic_unit_pipe #(.WIDTH(1), .CNT_W(4)) u_dut_n (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_a(n_in_a), .in_b(n_in_b), .in_op(n_in_op),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .out_zero(n_out_zero), .out_parity(n_out_parity), .op_count(n_op_count), .cnt_clr(n_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each op is a 2-input truth table, bit k of tt is the result for {a,b} == k.
    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [3:0]  tt;
        logic [31:0] r;
        case (op)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b1001;
            3'd4: tt = 4'b0111;
            3'd5: tt = 4'b0001;
            3'd6: tt = 4'b0100;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 32; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, where inputs and registered outputs are stable.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: out_data=%0h with no result outstanding", out_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    pops++;
                    chk("sb_data", out_data, e);
                    chk("sb_zero", out_zero, e == 0);
                    chk("sb_parity", out_parity, ^e);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_op(in_a, in_b, in_op));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        hs;
        logic [31:0] r;

        vecs[0] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 3'(OP_AND),   32'h00F0_1234};
        vecs[1] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 3'(OP_OR),    32'hFFF0_FFFF};
        vecs[2] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 3'(OP_XOR),   32'hFF00_EDCB};
        vecs[3] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 3'(OP_XNOR),  32'h00FF_1234};
        vecs[4] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 3'(OP_NAND),  32'hFF0F_EDCB};
        vecs[5] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 3'(OP_NOR),   32'h000F_0000};
        vecs[6] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 3'(OP_ANDN),  32'hF000_0000};
        vecs[7] = '{32'hF0F0_1234, 32'h0FF0_FFFF, 3'(OP_PASSA), 32'hF0F0_1234};
        vecs[8] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'(OP_XOR),   32'h0000_0000};
        vecs[9] = '{32'h0000_0007, 32'h1234_5678, 3'(OP_PASSA), 32'h0000_0007};

        rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 1; cnt_clr = 0;
        n_in_valid = 0; n_in_a = 0; n_in_b = 0; n_in_op = 0; n_out_ready = 1; n_cnt_clr = 0;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_zero", out_zero, 1);
        chk("rst_out_parity", out_parity, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_in_ready", in_ready, 1);
        #11 rst_n = 1;
        @(posedge clk); #1;

        // Back-to-back table with out_ready high: each result is visible one cycle later.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_a = vecs[i].a; in_b = vecs[i].b; in_op = vecs[i].op;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            chk($sformatf("vec%0d_zero", i), out_zero, vecs[i].exp == 0);
            chk($sformatf("vec%0d_parity", i), out_parity, ^vecs[i].exp);
            if (i == 7) chk("op_count_8", op_count, 8);
        end
        in_valid = 0;
        @(posedge clk); #1;
        chk("table_drain_valid", out_valid, 0);

        // Backpressure: X in out reg, Y in skid, Z held until space frees up.
        out_ready = 0;
        in_valid = 1; in_a = 32'h1111_0000; in_b = 32'h0000_1111; in_op = 3'(OP_OR);
        @(posedge clk); #1;
        chk("bp_x_valid", out_valid, 1);
        chk("bp_x_data", out_data, 32'h1111_1111);
        chk("bp_x_in_ready", in_ready, 1);
        in_a = 32'hFFFF_0000; in_b = 32'h0F0F_0F0F; in_op = 3'(OP_XOR);
        @(posedge clk); #1;
        chk("bp_y_in_ready", in_ready, 0);
        chk("bp_y_hold_x", out_data, 32'h1111_1111);
        in_a = 32'h1234_5678; in_b = 32'hFFFF_0000; in_op = 3'(OP_AND);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_z_in_ready", in_ready, 0);
        chk("bp_z_hold_x", out_data, 32'h1111_1111);
        chk("bp_z_valid", out_valid, 1);
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_y_out", out_data, 32'hF0F0_0F0F);
        chk("bp_y_in_ready_back", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_z_out", out_data, 32'h1234_0000);
        chk("bp_z_out_valid", out_valid, 1);
        in_valid = 0;
        @(posedge clk); #1;
        chk("bp_drain_valid", out_valid, 0);
        chk("op_count_13", op_count, 13);

        // Randomized traffic; held inputs stay stable until accepted.
        mon_en = 1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (!in_valid || hs) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a = $urandom;
                in_b = $urandom;
                in_op = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 0; out_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        mon_en = 0;
        chk("sb_queue_empty", exp_q.size(), 0);
        chk("sb_activity", pops > 200, 1);

        // Asynchronous reset with skid full and output valid.
        out_ready = 0;
        in_valid = 1; in_a = 32'hDEAD_BEEF; in_b = 32'h0; in_op = 3'(OP_PASSA);
        @(posedge clk); #1;
        in_a = 32'hCAFE_F00D; in_op = 3'(OP_NOR);
        @(posedge clk); #1;
        in_valid = 0;
        chk("mr_skid_full", in_ready, 0);
        chk("mr_out_valid", out_valid, 1);
        #3 rst_n = 0;
        #1;
        chk("mr_out_valid_rst", out_valid, 0);
        chk("mr_out_data_rst", out_data, 0);
        chk("mr_out_zero_rst", out_zero, 1);
        chk("mr_out_parity_rst", out_parity, 0);
        chk("mr_op_count_rst", op_count, 0);
        chk("mr_in_ready_rst", in_ready, 1);
        #2 rst_n = 1;
        out_ready = 1;
        @(posedge clk); #1;
        chk("mr_no_stale", out_valid, 0);
        in_valid = 1; in_a = 32'h0000_0007; in_b = 32'hFFFF_FFFF; in_op = 3'(OP_PASSA);
        @(posedge clk); #1;
        in_valid = 0;
        chk("mr_first_valid", out_valid, 1);
        chk("mr_first_data", out_data, 32'h0000_0007);
        chk("mr_first_parity", out_parity, 1);
        chk("mr_first_count", op_count, 1);
        @(posedge clk); #1;
        chk("mr_first_drain", out_valid, 0);

        // WIDTH=1 exhaustive sweep, also drives the 4-bit counter into saturation.
        for (int op = 0; op < 8; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                n_in_valid = 1; n_in_a = ab[1]; n_in_b = ab[0]; n_in_op = 3'(op);
                r = ref_op({31'b0, n_in_a}, {31'b0, n_in_b}, 3'(op));
                @(posedge clk); #1;
                chk($sformatf("w1_op%0d_ab%0d", op, ab), n_out_data, r[0]);
                chk($sformatf("w1_op%0d_ab%0d_zero", op, ab), n_out_zero, !r[0]);
                if (op * 4 + ab == 19) chk("cnt_sat_20", n_op_count, 15);
            end
        end
        chk("cnt_sat_32", n_op_count, 15);
        n_cnt_clr = 1;
        @(posedge clk); #1;
        n_cnt_clr = 0;
        chk("cnt_clr_with_accept", n_op_count, 0);
        @(posedge clk); #1;
        n_in_valid = 0;
        chk("cnt_after_clr", n_op_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit 2-input gate family: one WIDTH-bit bitwise logic unit covering eight ops, selected per transaction.
- One registered output stage plus a skid buffer, with valid/ready on both sides; flags and a saturating op counter are included.
- Sits between the RV32I decode/operand stage and writeback as the bitwise-ops path (AND/OR/XOR and friends).

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 1..64).
- CNT_W, 16, width of the saturating accepted-op counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  unit can accept; registered.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  operation code (see Behaviour).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  result.
- out_zero  out  1  out_data == 0.
- out_parity  out  1  XOR-reduce of out_data.
- op_count  out  CNT_W  accepted transactions, saturating.
- cnt_clr  in  1  synchronous clear of op_count.

Behaviour:
- Reset: async assert on rst_n low, released synchronously by design intent.
  - Reset values: out_valid=0, out_data=0, out_zero=1, out_parity=0, op_count=0, skid empty, in_ready=1.
  - Reset mid-transfer drops all in-flight results with no partial output.
- Op codes:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 ANDN (a & ~b), 7 PASS_A.
  - All ops are pure bitwise with no carries; every bit i depends only on a[i], b[i].
- Handshakes:
  - Input accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - in_valid held without ready: in_a/in_b/in_op must stay stable (AXI-style); the unit never samples unaccepted data.
- Latency and throughput:
  - Accepted op appears on out_data the next cycle if the output register is free or draining.
  - Sustained throughput 1 op/cycle with out_ready high.
- Output register / skid buffer:
  - out reg loads when (!out_valid || out_ready).
  - Source is the skid if skid is full, else the new accepted input.
  - If an input is accepted while out_valid && !out_ready, its result goes to the skid (1 entry); in_ready drops the next cycle.
  - in_ready = !skid_full (registered, no combinational path from out_ready).
  - Skid drains into out reg on the first cycle out_ready is seen; in_ready returns 1 the following cycle.
  - Order is preserved strictly FIFO.
- Flags: out_zero and out_parity are registered with out_data, from the same source result; they are never stale relative to out_data.
- op_count:
  - Increments on each input accept; saturates at all-ones with no wrap.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- No combinational path from in_* to out_*.

Decomposition:
- Shared package logic_pkg: op enum (OP_AND..OP_PASSA, 3-bit) and OP_W=3. Used by this block, the decode stage and benches.
- One sub-module, logic_op_comb (combinational, WIDTH-parametrised, a/b/op -> y). Instantiated once, on the input side of the skid/out-reg mux. The skid stores the computed result, not the operands.

Test Plan:
- WIDTH=32, out_ready=1, in_a=0xF0F0_1234, in_b=0x0FF0_FFFF, ops 0..7 back-to-back -> next-cycle out_data:
  - 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0x00FF_1234, 0xFF0F_EDCB, 0x000F_0000, 0xF000_0000, 0xF0F0_1234.
  - 8 consecutive out_valid cycles; op_count=8.
- XOR with a=b=0xA5A5_A5A5 -> out_data=0, out_zero=1, out_parity=0.
  - PASS_A a=0x0000_0007 -> out_zero=0, out_parity=1.
- Backpressure: out_ready=0, issue ops X then Y:
  - X sits in out reg, Y goes to skid, in_ready=0 next cycle, Z held stable.
  - Raise out_ready -> X, Y, Z emerge in order; no loss or duplication.
- CNT_W=4: issue 20 ops -> op_count=15 (saturated).
  - cnt_clr together with an accept -> op_count=0.
- Reset mid-operation: with skid full and out_valid=1, pull rst_n low asynchronously (not on a clock edge):
  - Outputs immediately go to reset values; in_ready=1 after release.
  - Next op behaves as first.
- WIDTH=1 exhaustive: all 4 (a,b) combinations × 8 ops vs the truth table, including XNOR giving 1,0,0,1 for ab=00,01,10,11.
